// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// Module   : stopwatch_ctrl
// Purpose  : Sequencing controller for the stopwatch digit-counter chain.
//            Turns tick and button pulses into cascade enables, direction and
//            a synchronous clear, and holds a lap snapshot for the display.
// Options  : STOPWATCH_COUNTDOWN_EN enables countdown mode (i_mode_down).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl #(
  parameter int                      NUM_DIGITS  = 4,
  parameter logic [4*NUM_DIGITS-1:0] BASE_PACKED = 16'h6AAA
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_tick,
  input  logic                      i_start_stop,
  input  logic                      i_clear,
  input  logic                      i_lap,
  input  logic                      i_mode_down,
  input  logic [4*NUM_DIGITS-1:0]   i_digits_in,
  output logic [NUM_DIGITS-1:0]     o_cnt_en,
  output logic                      o_cnt_up,
  output logic                      o_cnt_clr,
  output logic                      o_running,
  output logic                      o_done,
  output logic                      o_lap_active,
  output logic [4*NUM_DIGITS-1:0]   o_disp_digits
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_cnt_clr;
  logic                      r_lap_active;
  logic [4*NUM_DIGITS-1:0]   r_lap_snap;
  logic                      w_cnt_up;
  logic                      w_latch_dir;
  logic                      w_start_block;
  logic                      w_lap_set;
  logic                      w_lap_clr;
  logic [NUM_DIGITS-1:0]     w_term;
  logic [NUM_DIGITS-1:0]     w_en;
  logic                      w_all_term;

  // Per-digit terminal detection: BASE-1 counting up, 0 counting down
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_term
    logic [3:0] w_dig;
    logic [3:0] w_max;
    assign w_dig = i_digits_in[4*gi +: 4];
    assign w_max = BASE_PACKED[4*gi +: 4] - 4'd1;
`ifdef STOPWATCH_COUNTDOWN_EN
    assign w_term[gi] = w_cnt_up ? (w_dig == w_max) : (w_dig == 4'd0);
`else
    assign w_term[gi] = (w_dig == w_max);
`endif
  end

  assign w_all_term = &w_term;

  // Ripple cascade: a digit advances when the tick reaches it through
  // every lower digit sitting at its terminal value
  assign w_en[0] = i_tick & (r_state == S_RUN) & ~i_clear & ~w_all_term;
  for (genvar gc = 1; gc < NUM_DIGITS; gc++) begin : g_casc
    assign w_en[gc] = w_en[gc-1] & w_term[gc-1];
  end

`ifdef STOPWATCH_COUNTDOWN_EN
  logic r_cnt_up;
  // Direction is captured only when leaving IDLE for RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_cnt_up <= 1'b1;
    else if (w_latch_dir) r_cnt_up <= ~i_mode_down;
  end
  assign w_cnt_up      = r_cnt_up;
  // A countdown cannot start from an all-zero count
  assign w_start_block = i_mode_down & (i_digits_in == '0);
`else
  logic w_unused_mode;
  assign w_unused_mode = i_mode_down ^ w_latch_dir;
  assign w_cnt_up      = 1'b1;
  assign w_start_block = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and lap decisions; priority clear > start_stop > lap > tick
  always_comb begin
    w_next      = r_state;
    w_latch_dir = 1'b0;
    w_lap_set   = 1'b0;
    w_lap_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_clear && i_start_stop && !w_start_block) begin
          w_next      = S_RUN;
          w_latch_dir = 1'b1;
        end
      end
      S_RUN: begin
        if (i_clear) begin
          w_next = S_IDLE;
        end else if (i_start_stop) begin
          w_next = S_PAUSE;
        end else begin
          if (i_lap) begin
            w_lap_set = ~r_lap_active;
            w_lap_clr = r_lap_active;
          end
          if (i_tick && w_all_term) w_next = S_DONE;
        end
      end
      S_PAUSE: begin
        if (i_clear)           w_next = S_IDLE;
        else if (i_start_stop) w_next = S_RUN;
        else if (i_lap)        w_lap_clr = r_lap_active;
      end
      S_DONE: begin
        if (i_clear) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered one-cycle clear pulse and lap snapshot handling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_clr    <= 1'b0;
      r_lap_active <= 1'b0;
      r_lap_snap   <= '0;
    end else begin
      r_cnt_clr <= i_clear;
      if (i_clear)        r_lap_active <= 1'b0;
      else if (w_lap_set) r_lap_active <= 1'b1;
      else if (w_lap_clr) r_lap_active <= 1'b0;
      if (w_lap_set) r_lap_snap <= i_digits_in;
    end
  end

  assign o_cnt_en      = w_en;
  assign o_cnt_up      = w_cnt_up;
  assign o_cnt_clr     = r_cnt_clr;
  assign o_running     = (r_state == S_RUN);
  assign o_done        = (r_state == S_DONE);
  assign o_lap_active  = r_lap_active;
  assign o_disp_digits = r_lap_active ? r_lap_snap : i_digits_in;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// Module   : tb_stopwatch_ctrl
// Purpose  : Directed self-checking bench for stopwatch_ctrl with a behavioural
//            digit-counter bank closing the loop on cnt_en / cnt_up / cnt_clr.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctrl;

  localparam logic [15:0] c_BASE = 16'h6AAA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tick = 1'b0, i_start_stop = 1'b0, i_clear = 1'b0, i_lap = 1'b0;
  logic        i_mode_down = 1'b0;
  logic [15:0] r_digits;
  logic [3:0]  o_cnt_en;
  logic        o_cnt_up, o_cnt_clr, o_running, o_done, o_lap_active;
  logic [15:0] o_disp_digits;

  logic        r_ld = 1'b0;
  logic [15:0] r_ld_val = '0;
  logic [3:0]  r_en_pre = '0;
  logic [3:0]  r_en10 = '0;
  logic [3:0]  r_en100 = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  stopwatch_ctrl #(.NUM_DIGITS(4), .BASE_PACKED(c_BASE)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_tick       (i_tick),
    .i_start_stop (i_start_stop),
    .i_clear      (i_clear),
    .i_lap        (i_lap),
    .i_mode_down  (i_mode_down),
    .i_digits_in  (r_digits),
    .o_cnt_en     (o_cnt_en),
    .o_cnt_up     (o_cnt_up),
    .o_cnt_clr    (o_cnt_clr),
    .o_running    (o_running),
    .o_done       (o_done),
    .o_lap_active (o_lap_active),
    .o_disp_digits(o_disp_digits)
  );

  always #5 clk = ~clk;

  // Behavioural digit counter bank driven by the controller outputs
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits <= '0;
    end else if (r_ld) begin
      r_digits <= r_ld_val;
    end else if (o_cnt_clr) begin
      r_digits <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (o_cnt_en[i]) begin
          if (o_cnt_up)
            r_digits[4*i +: 4] <= (r_digits[4*i +: 4] == c_BASE[4*i +: 4] - 4'd1)
                                  ? 4'd0 : r_digits[4*i +: 4] + 4'd1;
          else
            r_digits[4*i +: 4] <= (r_digits[4*i +: 4] == 4'd0)
                                  ? c_BASE[4*i +: 4] - 4'd1 : r_digits[4*i +: 4] - 4'd1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, capture the combinational enables before the edge
  task automatic step(input logic tk, input logic ss, input logic cl, input logic lp);
    i_tick = tk; i_start_stop = ss; i_clear = cl; i_lap = lp;
    #1 r_en_pre = o_cnt_en;
    @(posedge clk); #1;
    i_tick = 1'b0; i_start_stop = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    r_ld = 1'b1; r_ld_val = v;
    @(posedge clk); #1;
    r_ld = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_running", o_running, 0);
    chk("rst_done", o_done, 0);
    chk("rst_cnt_up", o_cnt_up, 1);
    chk("rst_cnt_clr", o_cnt_clr, 0);
    chk("rst_lap", o_lap_active, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Up count to 1.50
    step(0, 1, 0, 0);
    chk("start_running", o_running, 1);
    for (int k = 1; k <= 150; k++) begin
      step(1, 0, 0, 0);
      if (k == 10)  r_en10  = r_en_pre;
      if (k == 100) r_en100 = r_en_pre;
    end
    chk("up_digits", r_digits, 32'h0150);
    chk("up_en_tick10", r_en10, 4'b0011);
    chk("up_en_tick100", r_en100, 4'b0111);
    chk("up_disp", o_disp_digits, 32'h0150);

    // Saturation at 0x5999
    step(0, 0, 1, 0);
    chk("clr_to_idle", o_running, 0);
    chk("clr_pulse", o_cnt_clr, 1);
    load(16'h5999);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("sat_en", r_en_pre, 4'b0000);
    chk("sat_done", o_done, 1);
    chk("sat_digits", r_digits, 32'h5999);
    step(0, 1, 0, 0);
    chk("sat_ss_ignored", o_done, 1);
    step(1, 0, 0, 0);
    chk("sat_hold", r_digits, 32'h5999);
    step(0, 0, 1, 0);
    chk("sat_clr_done", o_done, 0);
    chk("sat_clr_pulse", o_cnt_clr, 1);
    step(0, 0, 0, 0);
    chk("sat_clr_one", o_cnt_clr, 0);
    chk("sat_clr_digits", r_digits, 32'h0000);

    // Pause with simultaneous tick
    step(0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("pause_tick_counted", r_digits, 32'h0004);
    chk("pause_state", o_running, 0);
    chk("pause_not_done", o_done, 0);
    repeat (5) step(1, 0, 0, 0);
    chk("pause_hold", r_digits, 32'h0004);
    step(0, 1, 0, 0);
    chk("resume_running", o_running, 1);
    step(1, 0, 0, 0);
    chk("resume_count", r_digits, 32'h0005);

    // Lap snapshot at 0x0042
    step(0, 0, 1, 0);
    load(16'h0042);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("lap_set", o_lap_active, 1);
    chk("lap_disp", o_disp_digits, 32'h0042);
    repeat (58) step(1, 0, 0, 0);
    chk("lap_count_on", r_digits, 32'h0100);
    chk("lap_disp_held", o_disp_digits, 32'h0042);
    step(0, 0, 0, 1);
    chk("lap_off", o_lap_active, 0);
    chk("lap_disp_live", o_disp_digits, 32'h0100);
    step(1, 0, 0, 0);
    chk("lap_disp_track", o_disp_digits, 32'h0101);

    // Asynchronous reset mid-run with lap shown
    step(0, 0, 0, 1);
    chk("pre_rst_lap", o_lap_active, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_running", o_running, 0);
    chk("arst_lap", o_lap_active, 0);
    chk("arst_cnt_up", o_cnt_up, 1);
    chk("arst_cnt_clr", o_cnt_clr, 0);
    @(posedge clk); #1;
    chk("arst_no_clr", o_cnt_clr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef STOPWATCH_COUNTDOWN_EN
    // Countdown: zero-start rejection, then 3 -> 0 and DONE
    i_mode_down = 1'b1;
    step(0, 1, 0, 0);
    chk("dn_zero_reject", o_running, 0);
    load(16'h0003);
    step(0, 1, 0, 0);
    chk("dn_running", o_running, 1);
    chk("dn_dir", o_cnt_up, 0);
    repeat (3) step(1, 0, 0, 0);
    chk("dn_at_zero", r_digits, 32'h0000);
    chk("dn_not_done", o_done, 0);
    step(1, 0, 0, 0);
    chk("dn_done", o_done, 1);
    chk("dn_hold", r_digits, 32'h0000);
`else
    // Direction request has no effect without countdown support
    i_mode_down = 1'b1;
    step(0, 1, 0, 0);
    chk("nodn_running", o_running, 1);
    chk("nodn_dir", o_cnt_up, 1);
    step(1, 0, 0, 0);
    chk("nodn_count", r_digits, 32'h0001);
`endif
    i_mode_down = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the stopwatch digit-counter chain.
- Converts a periodic tick and debounced button pulses (start/stop, clear, lap) into per-digit cascade enables, count direction and a synchronous clear for the counters.
- Holds a lap snapshot for the display path.
- Sits between the button/prescaler front end and the digit counter bank plus display mux.

Parameters:
- NUM_DIGITS, 4, number of cascaded digit counters; digit 0 is least significant.
- BASE_PACKED, 16'h6AAA, per-digit base, 4 bits per digit, digit i at [4i+3:4i]; default gives hundredths, tenths, seconds (base 10) and tens of seconds (base 6).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- tick  in  1  one-cycle count strobe from prescaler
- start_stop  in  1  one-cycle pulse
- clear  in  1  one-cycle pulse
- lap  in  1  one-cycle pulse
- mode_down  in  1  count direction request: 1 = countdown; sampled only on the IDLE->RUN transition
- digits_in  in  4*NUM_DIGITS  current counter values
- cnt_en  out  NUM_DIGITS  per-digit count enable
- cnt_up  out  1  direction to counters: 1 = up
- cnt_clr  out  1  synchronous clear pulse to counters
- running  out  1  high in RUN
- done  out  1  high in DONE
- lap_active  out  1  display is showing the lap snapshot
- disp_digits  out  4*NUM_DIGITS  value to display: digits_in, or the lap snapshot when lap_active = 1

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On reset: state IDLE, cnt_up = 1, cnt_clr = 0, lap_active = 0, lap snapshot = 0, running = 0, done = 0.
  - Reset asserted mid-count returns to IDLE immediately and does not pulse cnt_clr; the counters share rst.
- States: IDLE, RUN, PAUSE, DONE. running and done are decoded from the state register.
- Input priority within a cycle: clear > start_stop > lap > tick.
- Terminal value per digit: BASE-1 when cnt_up = 1, 0 when cnt_up = 0. all_term = every digit is at its terminal value.
- cnt_en is combinational:
  - cnt_en[0] = tick & RUN & !clear & !all_term.
  - cnt_en[i] = cnt_en[i-1] & (digit i-1 at its terminal value).
  - Counters advance on the same edge that samples the tick; latency is 0 cycles from tick to enable.
- IDLE:
  - start_stop -> RUN, latching cnt_up = ~mode_down.
  - If the latched direction is down and all digits are 0, start_stop is ignored and the state stays IDLE.
  - clear -> cnt_clr pulse; state stays IDLE.
- RUN:
  - tick with !all_term -> cascade enables.
  - tick with all_term -> DONE; cnt_en = 0, so the count holds without wrapping (up mode holds at max, down mode holds at 0).
  - start_stop -> PAUSE. A tick in the same cycle is still counted.
  - clear -> IDLE with cnt_clr; a simultaneous tick is not counted.
- PAUSE:
  - start_stop -> RUN with direction unchanged.
  - clear -> IDLE with cnt_clr.
  - tick is ignored.
- DONE:
  - Only clear has effect: -> IDLE with cnt_clr.
  - start_stop and lap are ignored.
- cnt_clr: registered, exactly one cycle high, in the cycle after clear is sampled.
- Lap:
  - In RUN, a lap pulse with lap_active = 0 snapshots digits_in and sets lap_active.
  - A lap pulse with lap_active = 1 in RUN or PAUSE clears lap_active.
  - A lap pulse in PAUSE with lap_active = 0 is ignored.
  - clear and reset also clear lap_active.
  - disp_digits updates combinationally from digits_in when lap_active = 0.
- Width rules: all digit comparisons are 4-bit unsigned. A BASE_PACKED nibble of 0 or 1 is illegal; the block does not check for it.

Optional Feature:
- Macro: STOPWATCH_COUNTDOWN_EN.
- Defined: mode_down is honoured as described; countdown mode and the down-mode zero-start rejection are present.
- Undefined: mode_down is ignored and cnt_up stays 1 permanently. The terminal value is always BASE-1, and the down-direction logic is not synthesised.

Test Plan:
- Up count: reset, start_stop, 150 ticks -> digits 1.50 (0x0150); cnt_en[1] is high on the 10th tick together with cnt_en[0], and cnt_en[2] is high on the 100th tick.
- Up saturation: counters at 0x5999, RUN, tick -> done = 1, cnt_en = 0, digits stay 0x5999; a following start_stop has no effect; clear -> IDLE and cnt_clr high for 1 cycle.
- Pause and simultaneous events: in RUN, start_stop and tick in the same cycle -> that tick is counted and the state becomes PAUSE; 5 further ticks -> count unchanged; start_stop -> RUN resumes.
- Lap: at 0x0042, lap -> lap_active = 1 and disp_digits = 0x0042 while counting continues to 0x0100; lap -> disp_digits tracks digits_in.
- Countdown (macro defined): mode_down = 1, counters at 0x0000 -> start_stop ignored and state stays IDLE. With counters at 0x0003: start_stop, 4 ticks -> digits 0x0000 and DONE reached on the 4th tick.
- Async reset: assert rst mid-RUN with lap_active = 1 -> running = 0, lap_active = 0, cnt_up = 1 immediately, with no cnt_clr pulse.
